process_scheduler: RTL and testbench
====================================

# process_scheduler

Round-robin process scheduler for the multiprogrammed MIPS core. It sits directly downstream of the quantum timer: it consumes the timer's `quantum_end` and the core's `Halt`, and drives the timer's `Quantum_flag` enable. On a preemption or termination it drains the core, saves the running process's PC into a process table, picks the next active process, and reloads the core's PC.

## Interface
- `NUM_PROC`, default 4: number of process slots, a power of 2 and at least 2.
- `PC_WIDTH`, default 32: PC width.
- `PID_W`, default `$clog2(NUM_PROC)`: process-id width.

Ports:
- `Clock`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high.
- `quantum_end`  in  1  from the quantum timer; registered level.
- `Halt`  in  1  the running process executed halt; level, sampled in RUN.
- `pc_current`  in  PC_WIDTH  resume PC of the running process; valid while `switch_ack`=1.
- `switch_ack`  in  1  the core pipeline has drained; level.
- `proc_create`  in  1  1-cycle pulse requesting a new process.
- `proc_create_pc`  in  PC_WIDTH  start PC of the new process.
- `switch_req`  out  1  request to the core to stall and drain.
- `pc_load`  out  1  1-cycle pulse telling the core to load `pc_next`.
- `pc_next`  out  PC_WIDTH  PC of the selected process.
- `quantum_enable`  out  1  drives the timer's `Quantum_flag`.
- `current_pid`  out  PID_W  slot of the running or last-selected process.
- `table_full`  out  1  all slots are active.
- `idle`  out  1  no active process exists.

## Operation
- State per slot: an `active` bit and a `pc_table` entry.
- FSM states: IDLE, RUN, DRAIN, SAVE, SELECT, LOAD.
- **Create.** On a `proc_create` pulse with `table_full`=0:
  - The lowest-index inactive slot gets `active`=1 and `pc_table`=`proc_create_pc`.
  - Create is accepted in any state.
  - When `table_full`=1, the pulse is dropped silently.
- **IDLE.** If any slot is active, go to SELECT.
- **RUN.**
  - If `Halt`=1, go to DRAIN with terminate=1.
  - Otherwise, if `quantum_end`=1, go to DRAIN with terminate=0.
  - `Halt` has priority over `quantum_end`.
  - `quantum_end` is ignored in the first RUN cycle after LOAD, because the timer holds the previous quantum's level for one enabled cycle.
- **DRAIN.** `switch_req` is held at 1. When `switch_ack`=1, capture `pc_current` and go to SAVE.
- **SAVE.**
  - terminate=1: clear `active[current_pid]`.
  - terminate=0: write the captured PC to `pc_table[current_pid]`.
  - Then go to SELECT.
- **SELECT.**
  - Search slots `current_pid+1 … current_pid+NUM_PROC`, modulo NUM_PROC. The first active slot wins, so the current slot is considered last.
  - The search is combinational and completes in one cycle.
  - If a slot is found, latch it into `next_pid` and go to LOAD. If none is found, go to IDLE.
  - The search uses the `active` vector as registered, including any create that completed in an earlier cycle.
- **LOAD.** Set `current_pid`=`next_pid`, drive `pc_next`=`pc_table[next_pid]`, pulse `pc_load`=1, then go to RUN.
- **Outputs by state.**
  - `quantum_enable`=1 only in RUN.
  - `switch_req`=1 only in DRAIN.
  - `idle`=1 in IDLE.
  - `table_full` is the AND of all `active` bits.
  - All outputs are registered.
- **Reset.**
  - State goes to IDLE.
  - All `active`=0 and all `pc_table`=0.
  - `current_pid`=NUM_PROC-1, so the first selection lands on slot 0.
  - `switch_req`=0, `pc_load`=0, `pc_next`=0, `quantum_enable`=0, `table_full`=0, `idle`=1.
- A Reset during DRAIN or LOAD aborts the switch; no table write occurs.

## Timing
- Preemption sequence, with `switch_ack` tied high:
  - Cycle 0: RUN, `quantum_end`=1.
  - Cycle 1: DRAIN, `switch_req`=1.
  - Cycle 2: SAVE.
  - Cycle 3: SELECT.
  - Cycle 4: LOAD, `pc_load`=1.
  - Cycle 5: RUN, `quantum_enable`=1.
- Fixed latency is 4 cycles from `quantum_end` to `pc_load`, plus one cycle for each additional cycle `switch_ack` is held low.
- `quantum_enable` falls in the cycle `switch_req` rises, so the timer freezes and does not count during a switch.
- Create vs SAVE on the same cycle: no conflict. The terminated slot is active during SAVE, so create never picks it; that slot becomes free the following cycle.
- A create arriving in IDLE is visible by the next cycle: IDLE → SELECT → LOAD, giving `pc_load` 3 cycles after the pulse.

## Test plan
- **Boot.** Reset, then create with PC 0x0040 → `pc_load`=1 and `pc_next`=0x0040 three cycles later; `current_pid`=0; `quantum_enable`=1 on the next cycle.
- **Round robin.** Create PIDs 0, 1, 2 with PCs 0x100, 0x200, 0x300. Pulse `quantum_end` three times, with `pc_current`=0x104, 0x204, 0x304 at ack → loads are 0x200, 0x300, then 0x104. Each `pc_load` comes exactly 4 cycles after its `quantum_end`.
- **Terminate.** Two processes; `Halt` in PID 0 → slot 0 is cleared, PID 1 is loaded. Then `Halt` in PID 1 → `idle`=1, no `pc_load`, `quantum_enable`=0.
- **Drain stall.** Hold `switch_ack` low for 5 cycles after `quantum_end` → `switch_req` stays high for 6 cycles; `pc_current` is captured only at ack; `pc_load` arrives 9 cycles after `quantum_end`.
- **Full table.** Create NUM_PROC processes → `table_full`=1. A further create is dropped, with no table change. After a `Halt`, `table_full`=0 the cycle after SAVE.
- **Stale `quantum_end` and priority.** Hold `quantum_end`=1 through LOAD and the first RUN cycle → no new switch. `Halt` and `quantum_end` asserted together → the slot is terminated, not saved.

Source files
------------

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: drains the core on preemption or halt, saves the
// running PC into the process table and reloads the core with the next active slot.
module process_scheduler #(
  parameter int NUM_PROC = 4,
  parameter int PC_WIDTH = 32,
  parameter int PID_W    = $clog2(NUM_PROC)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                quantum_end,
  input  logic                Halt,
  input  logic [PC_WIDTH-1:0] pc_current,
  input  logic                switch_ack,
  input  logic                proc_create,
  input  logic [PC_WIDTH-1:0] proc_create_pc,
  output logic                switch_req,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                quantum_enable,
  output logic [PID_W-1:0]    current_pid,
  output logic                table_full,
  output logic                idle
);

  // state  | meaning
  // IDLE   | no active process, waiting for a create
  // RUN    | a process owns the core, quantum timer enabled
  // DRAIN  | switch requested, waiting for the pipeline to drain
  // SAVE   | store resume PC, or retire the slot on halt
  // SELECT | round-robin search for the next active slot
  // LOAD   | hand the selected PC to the core
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_SAVE, S_SELECT, S_LOAD
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_PROC-1:0] active, active_nxt;
  logic [PC_WIDTH-1:0] pc_table [NUM_PROC];
  logic [PC_WIDTH-1:0] saved_pc;
  logic                terminate;
  logic                first_run;
  logic                create_ok;
  logic [PID_W-1:0]    free_pid;
  logic [PID_W-1:0]    sel_pid;
  logic                sel_found;

  // Both scans run backwards so the last hit is the highest-priority one.
  always_comb begin
    free_pid = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (!active[i]) free_pid = PID_W'(i);
    end
    sel_pid   = current_pid;
    sel_found = 1'b0;
    for (int k = NUM_PROC; k >= 1; k--) begin
      if (active[current_pid + PID_W'(k)]) begin
        sel_pid   = current_pid + PID_W'(k);
        sel_found = 1'b1;
      end
    end
  end

  assign create_ok = proc_create && !table_full;

  always_comb begin
    active_nxt = active;
    if (create_ok) active_nxt[free_pid] = 1'b1;
    if (state == S_SAVE && terminate) active_nxt[current_pid] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (|active) state_nxt = S_SELECT;
      // The timer still shows the old quantum's level in the first RUN cycle.
      S_RUN:    if (Halt || (quantum_end && !first_run)) state_nxt = S_DRAIN;
      S_DRAIN:  if (switch_ack) state_nxt = S_SAVE;
      S_SAVE:   state_nxt = S_SELECT;
      S_SELECT: state_nxt = sel_found ? S_LOAD : S_IDLE;
      S_LOAD:   state_nxt = S_RUN;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= S_IDLE;
      active         <= '0;
      for (int i = 0; i < NUM_PROC; i++) pc_table[i] <= '0;
      saved_pc       <= '0;
      terminate      <= 1'b0;
      first_run      <= 1'b0;
      current_pid    <= PID_W'(NUM_PROC - 1);
      pc_next        <= '0;
      switch_req     <= 1'b0;
      pc_load        <= 1'b0;
      quantum_enable <= 1'b0;
      table_full     <= 1'b0;
      idle           <= 1'b1;
    end else begin
      state      <= state_nxt;
      active     <= active_nxt;
      table_full <= &active_nxt;
      first_run  <= (state == S_LOAD);
      if (create_ok) pc_table[free_pid] <= proc_create_pc;
      if (state == S_SAVE && !terminate) pc_table[current_pid] <= saved_pc;
      if (state == S_RUN && state_nxt == S_DRAIN) terminate <= Halt;
      if (state == S_DRAIN && switch_ack) saved_pc <= pc_current;
      if (state == S_SELECT && sel_found) begin
        current_pid <= sel_pid;
        pc_next     <= pc_table[sel_pid];
      end
      switch_req     <= (state_nxt == S_DRAIN);
      pc_load        <= (state_nxt == S_LOAD);
      quantum_enable <= (state_nxt == S_RUN);
      idle           <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: cycle model of the scheduling rules checked every
// cycle, plus directed scenarios with hand-computed latencies and PCs.
module tb_process_scheduler;
  localparam int NP = 4;
  localparam int PW = 32;
  localparam int IW = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_SAVE = 3, M_SELECT = 4, M_LOAD = 5;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          quantum_end = 1'b0, Halt = 1'b0, switch_ack = 1'b1, proc_create = 1'b0;
  logic [PW-1:0] pc_current = '0, proc_create_pc = '0;
  logic          switch_req, pc_load, quantum_enable, table_full, idle;
  logic [PW-1:0] pc_next;
  logic [IW-1:0] current_pid;

  int n_vec = 0;
  int n_err = 0;

  process_scheduler #(.NUM_PROC(NP), .PC_WIDTH(PW)) dut (
    .Clock(Clock), .Reset(Reset), .quantum_end(quantum_end), .Halt(Halt),
    .pc_current(pc_current), .switch_ack(switch_ack), .proc_create(proc_create),
    .proc_create_pc(proc_create_pc), .switch_req(switch_req), .pc_load(pc_load),
    .pc_next(pc_next), .quantum_enable(quantum_enable), .current_pid(current_pid),
    .table_full(table_full), .idle(idle)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: slot bookkeeping with plain arrays; where the scheduler is in a switch.
  bit            m_ok = 1'b0;
  int            m_st;
  bit            m_act [NP];
  logic [PW-1:0] m_pc  [NP];
  int            m_cur;
  logic [PW-1:0] m_pcn, m_cap;
  bit            m_term;
  int            m_run_age;

  task automatic model_step();
    bit            old_act [NP];
    logic [PW-1:0] old_pc  [NP];
    bit            full, any;
    int            slot;
    if (Reset) begin
      m_ok = 1'b1; m_st = M_IDLE; m_cur = NP - 1; m_pcn = '0; m_term = 1'b0; m_run_age = 0;
      for (int i = 0; i < NP; i++) begin m_act[i] = 1'b0; m_pc[i] = '0; end
      return;
    end
    if (!m_ok) return;
    old_act = m_act; old_pc = m_pc; full = 1'b1; any = 1'b0;
    for (int i = 0; i < NP; i++) begin full &= old_act[i]; any |= old_act[i]; end
    if (proc_create && !full) begin
      slot = -1;
      for (int i = 0; i < NP; i++) if (slot < 0 && !old_act[i]) slot = i;
      m_act[slot] = 1'b1; m_pc[slot] = proc_create_pc;
    end
    case (m_st)
      M_IDLE: if (any) m_st = M_SELECT;
      M_RUN: begin
        if (Halt) begin m_term = 1'b1; m_st = M_DRAIN; end
        else if (quantum_end && m_run_age > 0) begin m_term = 1'b0; m_st = M_DRAIN; end
        m_run_age++;
      end
      M_DRAIN: if (switch_ack) begin m_cap = pc_current; m_st = M_SAVE; end
      M_SAVE: begin
        if (m_term) m_act[m_cur] = 1'b0; else m_pc[m_cur] = m_cap;
        m_st = M_SELECT;
      end
      M_SELECT: begin
        slot = -1;
        for (int k = 1; k <= NP; k++) if (slot < 0 && old_act[(m_cur + k) % NP]) slot = (m_cur + k) % NP;
        if (slot >= 0) begin m_cur = slot; m_pcn = old_pc[slot]; m_st = M_LOAD; end
        else m_st = M_IDLE;
      end
      default: begin m_st = M_RUN; m_run_age = 0; end
    endcase
  endtask

  initial forever begin
    @(posedge Clock);
    model_step();
  end

  initial forever begin
    bit full;
    @(negedge Clock);
    if (m_ok && !Reset) begin
      full = 1'b1;
      for (int i = 0; i < NP; i++) full &= m_act[i];
      check("cyc.switch_req", 64'(switch_req), 64'(m_st == M_DRAIN));
      check("cyc.pc_load", 64'(pc_load), 64'(m_st == M_LOAD));
      check("cyc.quantum_enable", 64'(quantum_enable), 64'(m_st == M_RUN));
      check("cyc.idle", 64'(idle), 64'(m_st == M_IDLE));
      check("cyc.table_full", 64'(table_full), 64'(full));
      check("cyc.current_pid", 64'(current_pid), 64'(m_cur));
      check("cyc.pc_next", 64'(pc_next), 64'(m_pcn));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1; quantum_end = 1'b0; Halt = 1'b0; switch_ack = 1'b1;
    proc_create = 1'b0; proc_create_pc = '0; pc_current = '0;
    cyc(2);
    Reset = 1'b0;
    check("rst.idle", 64'(idle), 64'd1);
    check("rst.table_full", 64'(table_full), 64'd0);
    check("rst.current_pid", 64'(current_pid), 64'd3);
    check("rst.pc_next", 64'(pc_next), 64'd0);
    check("rst.quantum_enable", 64'(quantum_enable), 64'd0);
    check("rst.switch_req", 64'(switch_req), 64'd0);
    check("rst.pc_load", 64'(pc_load), 64'd0);
  endtask

  task automatic create(input logic [PW-1:0] pc);
    proc_create = 1'b1; proc_create_pc = pc;
    cyc(1);
    proc_create = 1'b0;
  endtask

  // Counts cycles from the current one until pc_load; -1 if none within max.
  task automatic wait_load(input int max, output int lat);
    lat = -1;
    for (int n = 1; n <= max && lat < 0; n++) begin
      @(negedge Clock);
      proc_create = 1'b0; quantum_end = 1'b0; Halt = 1'b0;
      if (pc_load === 1'b1) lat = n;
    end
  endtask

  task automatic switch_expect(input string name, input logic [PW-1:0] resume_pc,
                               input logic [PW-1:0] exp_pc, input int exp_pid);
    int lat;
    pc_current = resume_pc; quantum_end = 1'b1;
    wait_load(10, lat);
    check({name, ".latency"}, 64'(lat), 64'd4);
    check({name, ".pc_next"}, 64'(pc_next), 64'(exp_pc));
    check({name, ".pid"}, 64'(current_pid), 64'(exp_pid));
    cyc(2);
  endtask

  initial begin
    int lat, sreq, stale;

    // Boot
    do_reset();
    proc_create = 1'b1; proc_create_pc = 32'h40;
    wait_load(8, lat);
    check("boot.latency", 64'(lat), 64'd3);
    check("boot.pc_next", 64'(pc_next), 64'h40);
    check("boot.pid", 64'(current_pid), 64'd0);
    cyc(1);
    check("boot.quantum_enable", 64'(quantum_enable), 64'd1);

    // Round robin
    do_reset();
    create(32'h100); create(32'h200); create(32'h300);
    cyc(3);
    switch_expect("rr1", 32'h104, 32'h200, 1);
    switch_expect("rr2", 32'h204, 32'h300, 2);
    switch_expect("rr3", 32'h304, 32'h104, 0);

    // Terminate
    do_reset();
    create(32'h500); create(32'h600);
    cyc(3);
    Halt = 1'b1;
    wait_load(10, lat);
    check("term1.latency", 64'(lat), 64'd4);
    check("term1.pc_next", 64'(pc_next), 64'h600);
    check("term1.pid", 64'(current_pid), 64'd1);
    cyc(2);
    Halt = 1'b1;
    wait_load(10, lat);
    check("term2.no_load", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    check("term2.idle", 64'(idle), 64'd1);
    check("term2.quantum_enable", 64'(quantum_enable), 64'd0);

    // Drain stall
    do_reset();
    create(32'h700); create(32'h800);
    cyc(3);
    quantum_end = 1'b1; switch_ack = 1'b0; pc_current = 32'hBAD0;
    sreq = 0; lat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge Clock);
      quantum_end = 1'b0;
      if (switch_req === 1'b1) sreq++;
      if (pc_load === 1'b1 && lat < 0) lat = n;
      if (n == 6) begin switch_ack = 1'b1; pc_current = 32'h7A0; end
      else pc_current = 32'hBAD0 + 32'(n);
    end
    check("stall.switch_req_cycles", 64'(sreq), 64'd6);
    check("stall.latency", 64'(lat), 64'd9);
    check("stall.pc_next", 64'(pc_next), 64'h800);
    switch_expect("stall.resume", 32'h8F0, 32'h7A0, 0);

    // Full table
    do_reset();
    create(32'h1000); create(32'h1100); create(32'h1200); create(32'h1300);
    check("full.table_full", 64'(table_full), 64'd1);
    create(32'h9999);
    check("full.dropped", 64'(table_full), 64'd1);
    cyc(1);
    Halt = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge Clock);
      Halt = 1'b0;
      if (n == 2) check("full.during_save", 64'(table_full), 64'd1);
      if (n == 3) check("full.after_save", 64'(table_full), 64'd0);
    end
    check("full.halt_load", 64'(pc_load), 64'd1);
    check("full.halt_pc", 64'(pc_next), 64'h1100);
    create(32'h2000);
    cyc(1);
    switch_expect("full.rr1", 32'h1104, 32'h1200, 2);
    switch_expect("full.rr2", 32'h1204, 32'h1300, 3);
    switch_expect("full.reuse", 32'h1304, 32'h2000, 0);

    // Stale quantum_end, then Halt/quantum_end priority
    do_reset();
    create(32'hA00); create(32'hB00);
    cyc(3);
    pc_current = 32'hA10; quantum_end = 1'b1;
    lat = -1; stale = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge Clock);
      if (n == 6) quantum_end = 1'b0;
      if (pc_load === 1'b1 && lat < 0) lat = n;
      if (n >= 6 && switch_req === 1'b1) stale++;
    end
    check("stale.latency", 64'(lat), 64'd4);
    check("stale.no_reswitch", 64'(stale), 64'd0);
    check("stale.pc_next", 64'(pc_next), 64'hB00);
    Halt = 1'b1; quantum_end = 1'b1; pc_current = 32'hB44;
    wait_load(10, lat);
    check("prio.latency", 64'(lat), 64'd4);
    check("prio.pc_next", 64'(pc_next), 64'hA10);
    cyc(2);
    switch_expect("prio.only_one", 32'hA44, 32'hA44, 0);

    // Reset in the middle of a drain
    switch_ack = 1'b0; quantum_end = 1'b1;
    cyc(1);
    quantum_end = 1'b0;
    check("abort.switch_req", 64'(switch_req), 64'd1);
    do_reset();
    cyc(3);
    check("abort.idle", 64'(idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
